// File: rtl/johnson_slot_arbiter.sv
// Four-requester time-slot arbiter sequenced by a 4-stage Johnson counter.
// Each of the 8 phases has a fixed owner; idle slots are passed on in rotating order.
module johnson_slot_arbiter #(
    parameter int SLOT_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_i,
    input  logic [3:0] req_i,
    input  logic       load_i,
    input  logic [3:0] load_phase_i,
    input  logic       err_clr_i,
    output logic [3:0] phase_o,
    output logic [2:0] slot_o,
    output logic [3:0] grant_o,
    output logic       slot_start_o,
    output logic       err_illegal_o
);

    localparam int            TW     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(SLOT_CYCLES - 1);

    logic [3:0]    phase_q, phase_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    grant_q, grant_d;
    logic          slot_start_q, slot_start_d;
    logic          err_q, err_d;

    logic [2:0]    slot;
    logic          legal;

    // Owner gets first look; otherwise search owner+1..owner+3 with 2-bit wrap.
    function automatic logic [3:0] pick_grant(input logic [1:0] owner, input logic [3:0] req);
        logic [3:0] g;
        logic [1:0] idx;
        g = 4'b0000;
        for (int k = 3; k >= 0; k--) begin
            idx = owner + 2'(k);
            if (req[idx]) g = 4'b0001 << idx;
        end
        return g;
    endfunction

    always_comb begin
        slot  = 3'd0;
        legal = 1'b1;
        case (phase_q)
            4'b0000: slot = 3'd0;
            4'b1000: slot = 3'd1;
            4'b1100: slot = 3'd2;
            4'b1110: slot = 3'd3;
            4'b1111: slot = 3'd4;
            4'b0111: slot = 3'd5;
            4'b0011: slot = 3'd6;
            4'b0001: slot = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q;
        grant_d = 4'b0000;
        err_d   = err_q;

        if (!legal) begin
            phase_d = 4'b0000;
            timer_d = RELOAD;
        end else if (load_i) begin
            phase_d = load_phase_i;
            timer_d = RELOAD;
        end else if (enable_i && (timer_q == '0)) begin
            phase_d = {~phase_q[0], phase_q[3:1]};
            timer_d = RELOAD;
        end else if (enable_i) begin
            timer_d = timer_q - TW'(1);
        end

        // Selection looks at the phase present now, not the one being loaded/stepped to.
        if (enable_i && legal) begin
            grant_d = pick_grant(slot[1:0], req_i);
        end

        if (!legal) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end

        slot_start_d = (phase_d != phase_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q      <= 4'b0000;
            timer_q      <= RELOAD;
            grant_q      <= 4'b0000;
            slot_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            slot_start_q <= slot_start_d;
            err_q        <= err_d;
        end
    end

    assign phase_o       = phase_q;
    assign slot_o        = slot;
    assign grant_o       = grant_q;
    assign slot_start_o  = slot_start_q;
    assign err_illegal_o = err_q;

endmodule

// File: tb/tb_johnson_slot_arbiter.sv
// Randomized bench for johnson_slot_arbiter against a slot-index reference model,
// plus directed illegal-load, fairness and asynchronous-reset scenarios.
module tb_johnson_slot_arbiter;

    localparam int SC = 2;
    localparam logic [3:0] CODES [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                                         4'b1111, 4'b0111, 4'b0011, 4'b0001};

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic       load;
    logic [3:0] load_phase;
    logic       err_clr;
    logic [3:0] phase;
    logic [2:0] slot;
    logic [3:0] grant;
    logic       slot_start;
    logic       err_illegal;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [3:0] m_phase;
    int         m_timer;
    logic [3:0] m_grant;
    logic       m_ss;
    logic       m_err;

    johnson_slot_arbiter #(.SLOT_CYCLES(SC)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable_i     (enable),
        .req_i        (req),
        .load_i       (load),
        .load_phase_i (load_phase),
        .err_clr_i    (err_clr),
        .phase_o      (phase),
        .slot_o       (slot),
        .grant_o      (grant),
        .slot_start_o (slot_start),
        .err_illegal_o(err_illegal)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int slot_of(input logic [3:0] p);
        for (int i = 0; i < 8; i++) if (CODES[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 4'b0000;
        m_timer = SC - 1;
        m_grant = 4'b0000;
        m_ss    = 1'b0;
        m_err   = 1'b0;
    endtask

    // One rising edge of the arbiter, written from the slot/owner rules.
    task automatic model_edge();
        int         s;
        int         owner;
        int         r;
        logic [3:0] np;
        int         nt;
        logic [3:0] ng;
        s  = slot_of(m_phase);
        np = m_phase;
        nt = m_timer;
        ng = 4'b0000;
        if (s < 0) begin
            np = 4'b0000; nt = SC - 1;
        end else if (load) begin
            np = load_phase; nt = SC - 1;
        end else if (enable && m_timer == 0) begin
            np = CODES[(s + 1) % 8]; nt = SC - 1;
        end else if (enable) begin
            nt = m_timer - 1;
        end
        if (enable && s >= 0) begin
            owner = s % 4;
            for (int k = 0; k < 4; k++) begin
                r = (owner + k) % 4;
                if (req[r]) begin
                    ng = 4'b0001 << r;
                    break;
                end
            end
        end
        m_ss    = (np != m_phase);
        m_err   = (s < 0) ? 1'b1 : (err_clr ? 1'b0 : m_err);
        m_phase = np;
        m_timer = nt;
        m_grant = ng;
    endtask

    task automatic compare_all(input string tag);
        int s;
        s = slot_of(m_phase);
        check({tag, ".phase"}, 32'(phase), 32'(m_phase));
        check({tag, ".slot"},  32'(slot), (s < 0) ? 32'd0 : 32'(s));
        check({tag, ".grant"}, 32'(grant), 32'(m_grant));
        check({tag, ".sstart"}, 32'(slot_start), 32'(m_ss));
        check({tag, ".err"},   32'(err_illegal), 32'(m_err));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        int cnt [4];
        bit found;
        reset = 1'b0; enable = 1'b0; req = 4'b0000;
        load = 1'b0; load_phase = 4'b0000; err_clr = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        reset = 1'b1;

        // Free run, no requests: explicit phase walk and wrap
        enable = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            step("free");
            check("free.seq", 32'(phase), 32'(CODES[(c / SC) % 8]));
            check("free.grant0", 32'(grant), 32'd0);
        end

        // Illegal load 1010 with no requests
        load = 1'b1; load_phase = 4'b1010;
        step("ill1");
        check("ill1.phase", 32'(phase), 32'h0000000a);
        check("ill1.grant", 32'(grant), 32'd0);
        load = 1'b0;
        step("ill2");
        check("ill2.phase", 32'(phase), 32'd0);
        check("ill2.err", 32'(err_illegal), 32'd1);
        check("ill2.sstart", 32'(slot_start), 32'd1);
        err_clr = 1'b1;
        step("clr");
        check("clr.err", 32'(err_illegal), 32'd0);
        load = 1'b1;
        step("ill3");
        load = 1'b0;
        step("ill4");
        check("setwins.err", 32'(err_illegal), 32'd1);
        err_clr = 1'b0;

        // Fairness: req=1111 for a full frame after one warm-up cycle
        req = 4'b1111;
        step("warm");
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 8 * SC; c++) begin
            step("fair");
            for (int i = 0; i < 4; i++) if (grant[i]) cnt[i]++;
        end
        for (int i = 0; i < 4; i++) check("fair.count", 32'(cnt[i]), 32'(2 * SC));

        // Work-conserving: a lone requester is never starved
        req = 4'b0100;
        step("wc_warm");
        for (int c = 0; c < 8 * SC; c++) begin
            step("wc");
            check("wc.grant", 32'(grant), 32'h4);
        end

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            enable     = ($urandom_range(0, 9) != 0);
            req        = 4'($urandom_range(0, 15));
            load       = ($urandom_range(0, 19) == 0);
            load_phase = 4'($urandom_range(0, 15));
            err_clr    = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        // Asynchronous reset while grant=1000
        enable = 1'b1; load = 1'b0; err_clr = 1'b0; req = 4'b1000;
        found = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            step("rwait");
            if (grant == 4'b1000 && m_grant == 4'b1000) found = 1'b1;
        end
        check("rst.found", 32'(found), 32'd1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all("arst");
        #2;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) step("post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/johnson_slot_arbiter.md
# johnson_slot_arbiter

Time-slot arbiter that shares one downstream resource among four requesters. It is sequenced by an internal 4-stage Johnson (twisted-ring) counter that steps through 8 legal phases, one per time slot. Each slot has a fixed owner. Unused slots are passed to other requesters in rotating order, so the arbiter is work-conserving. The block also detects illegal Johnson states and recovers from them, and it supports a phase load for synchronisation and test.

## Interface
- SLOT_CYCLES, 2: number of clock cycles each phase is held. Legal range is 1..16.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = run the counter and issue grants; 0 = freeze the counter and drop grants.
- req  input  4  request vector; req[i] is the level request from requester i.
- load  input  1  force the phase register to load_phase.
- load_phase  input  4  value to load; any 4-bit value is accepted, including illegal ones.
- err_clr  input  1  clears err_illegal.
- phase  output  4  Johnson state {a,b,c,e}.
- slot  output  3  decoded slot index.
- grant  output  4  registered one-hot grant, or all zeros.
- slot_start  output  1  one-cycle pulse in the cycle after phase changes.
- err_illegal  output  1  sticky illegal-state flag.

## Operation
- **Johnson step:** a<=~e, b<=a, c<=b, e<=c.
  - Phase sequence: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then back to 0000.
  - These decode to slot 0..7 in that order.
  - The other 8 codes are illegal; slot decodes to 0 for an illegal code.
- **Slot timer:** counts down from SLOT_CYCLES-1. When the timer reaches 0 with enable=1, phase steps and the timer reloads SLOT_CYCLES-1.
- **Update priority at each edge (highest first):**
  1. Illegal: the current phase is illegal. Next phase is 0000, the timer reloads, err_illegal is set, and grant is all zeros. This applies regardless of enable and load.
  2. load=1: phase<=load_phase and the timer reloads.
  3. enable=1 and timer=0: step the phase.
  4. enable=1: decrement the timer.
  5. enable=0: hold the phase and the timer.
- **Slot ownership:** owner(s) = s mod 4, so each requester owns two slots per 8-slot frame.
- **Grant selection (registered):**
  - If enable=0 or the phase is illegal, grant<=0.
  - Else if req[owner] is set, grant<=onehot(owner).
  - Else grant goes to the first requester with req set, searching owner+1, owner+2, owner+3 (mod 4).
  - If no requester has req set, grant<=0.
  - Selection uses the phase and req present at the edge, not the next phase.
- **slot_start:** set to 1 for exactly one cycle after any edge that changes phase (step, load of a different value, or illegal recovery). Otherwise 0.
- **err_illegal:** sticky and cleared by err_clr. If err_clr and a new illegal detection occur at the same edge, set wins.

## Timing
- **Reset values:** phase=0000, slot=0, timer=SLOT_CYCLES-1, grant=0000, slot_start=0, err_illegal=0.
- **Request-to-grant latency:** 1 cycle. Grant responds to a req change at the next edge.
- **Grant at a slot boundary:** during the first cycle of a new slot, grant still reflects the previous slot's selection. The new owner's grant appears one cycle later.
- **Frame period:** 8×SLOT_CYCLES cycles with enable held at 1.
- **enable deasserted:** grant goes to 0 at the next edge. The phase and timer resume from their held values when enable returns.
- **Illegal-state recovery:** 1 edge. A legal phase is guaranteed no more than 1 cycle after any load.
- **Reset mid-operation:** all state returns to reset values immediately; no partial grant survives.

## Test plan
- **Free run:** reset, enable=1, req=0000, SLOT_CYCLES=2.
  - Phase visits 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001 and wraps at cycle 16.
  - slot_start pulses every 2 cycles.
  - grant stays 0000.
- **Owner priority:** req=1111 held.
  - grant follows 0001, 0010, 0100, 1000, 0001, …, each one slot lagged by 1 cycle.
  - Each requester receives exactly 4 grant cycles per 16-cycle frame.
- **Work-conserving fallback:** req=0100 only.
  - In slot 0 (owner 0), grant=0100.
  - In slots 3 and 7 (owner 3), the search order is 0, 1, 2, giving grant=0100.
  - grant is never zero while req=0100.
- **Illegal load:** load=1 with load_phase=1010.
  - Next cycle: phase=1010 and grant=0000.
  - The following cycle: phase=0000, err_illegal=1, slot_start=1.
  - err_clr=1 then clears the flag; err_clr together with another illegal load leaves the flag at 1.
- **Freeze:** drop enable in slot 5 with req=1111.
  - grant=0000 from the next cycle.
  - phase stays 0111 while frozen.
  - After re-enable, the remaining timer count is honoured and grant=0010 one cycle later.
- **Async reset:** assert reset mid-slot with grant=1000. All outputs go to their reset values without waiting for a clock edge.
